// File: rtl/offchip_mem_model_nch_if.sv
// ----------------------------------------------------------------------------
// offchip_mem_model_nch_if
// Bundle of the per-channel Mout_* style memory bus plus the preload port.
// All channel fields are flat vectors; channel c occupies slice [c*W +: W].
//   ch_oe / ch_we       per-channel read / write enable   (master -> slave)
//   ch_addr             per-channel address               (master -> slave)
//   ch_wdata / ch_size  per-channel write data / bit size (master -> slave)
//   ch_rdata            per-channel read data             (slave -> master)
//   ch_rdy              per-channel DataRdy               (slave -> master)
//   err                 sticky per-channel protocol error (slave -> master)
//   load_en/addr/data   preload strobe, array index, word (master -> slave)
// ----------------------------------------------------------------------------
interface offchip_mem_model_nch_if #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int MEMSIZE = 64
) ();
    localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

    logic [N_CH-1:0]        ch_oe;
    logic [N_CH-1:0]        ch_we;
    logic [N_CH*ADDR_W-1:0] ch_addr;
    logic [N_CH*DATA_W-1:0] ch_wdata;
    logic [N_CH*SIZE_W-1:0] ch_size;
    logic [N_CH*DATA_W-1:0] ch_rdata;
    logic [N_CH-1:0]        ch_rdy;
    logic [N_CH-1:0]        err;
    logic                   load_en;
    logic [IDX_W-1:0]       load_addr;
    logic [DATA_W-1:0]      load_data;

    modport master (
        output ch_oe, ch_we, ch_addr, ch_wdata, ch_size,
        output load_en, load_addr, load_data,
        input  ch_rdata, ch_rdy, err
    );

    modport slave (
        input  ch_oe, ch_we, ch_addr, ch_wdata, ch_size,
        input  load_en, load_addr, load_data,
        output ch_rdata, ch_rdy, err
    );
endinterface

// File: rtl/offchip_mem_model_nch.sv
// ----------------------------------------------------------------------------
// offchip_mem_model_nch
// Multi-channel off-chip memory model: N_CH independent master channels share
// one word array. Each channel has its own latency counter, DataRdy handshake,
// size-masked writes and a sticky protocol-error flag (oe and we together).
// Ports:
//   clock  single rising-edge clock
//   reset  synchronous active-high reset (array contents are kept)
//   bus    offchip_mem_model_nch_if.slave (channel buses + preload port)
// ch_rdy is combinational from the counter and current request; ch_rdata is a
// register that samples the addressed word every clock while in range.
// load_addr must stay below MEMSIZE.
// ----------------------------------------------------------------------------
module offchip_mem_model_nch #(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int SIZE_W    = 4,
    parameter int MEMSIZE   = 64,
    parameter int BASE_ADDR = 0,
    parameter int RD_DELAY  = 2,
    parameter int WR_DELAY  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    offchip_mem_model_nch_if.slave   bus
);
    localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam int MAX_D = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
    localparam int CNT_W = (MAX_D > 1) ? $clog2(MAX_D) : 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_DELAY - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_DELAY - 1);

    // Bit mask covering the low 'size' bits; sizes >= DATA_W give all ones.
    function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(size)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    logic [DATA_W-1:0]      mem_q   [MEMSIZE];
    logic [CNT_W-1:0]       cnt_q   [N_CH];
    logic [CNT_W-1:0]       cnt_d   [N_CH];
    logic [DATA_W-1:0]      rdata_q [N_CH];
    logic [DATA_W-1:0]      rdata_d [N_CH];
    logic [N_CH-1:0]        err_q;
    logic [N_CH-1:0]        err_d;

    logic [31:0]            off_s    [N_CH];
    logic [IDX_W-1:0]       idx_s    [N_CH];
    logic [DATA_W-1:0]      wmerge_s [N_CH];
    logic [N_CH-1:0]        in_range_s;
    logic [N_CH-1:0]        rd_act_s;
    logic [N_CH-1:0]        wr_act_s;
    logic [N_CH-1:0]        rdy_s;
    logic [N_CH-1:0]        commit_s;
    logic [N_CH*DATA_W-1:0] rdata_flat_s;

    // Per-channel decode: range check, counter next state, handshake, read/write data.
    always_comb begin
        in_range_s   = '0;
        rd_act_s     = '0;
        wr_act_s     = '0;
        rdy_s        = '0;
        commit_s     = '0;
        err_d        = err_q;
        rdata_flat_s = '0;
        for (int c = 0; c < N_CH; c++) begin
            // Offset wraps to a huge value below BASE_ADDR, so one compare covers both bounds.
            off_s[c]      = 32'(bus.ch_addr[c*ADDR_W +: ADDR_W]) - 32'(BASE_ADDR);
            in_range_s[c] = (off_s[c] < 32'(MEMSIZE));
            idx_s[c]      = IDX_W'(off_s[c]);

            // oe and we together is a protocol error: no access on that channel.
            rd_act_s[c] = in_range_s[c] & bus.ch_oe[c] & ~bus.ch_we[c];
            wr_act_s[c] = in_range_s[c] & bus.ch_we[c] & ~bus.ch_oe[c];
            err_d[c]    = err_q[c] | (bus.ch_oe[c] & bus.ch_we[c]);

            if (rd_act_s[c]) begin
                cnt_d[c] = (cnt_q[c] < RD_LAST) ? (cnt_q[c] + CNT_W'(1)) : '0;
            end else if (wr_act_s[c]) begin
                cnt_d[c] = (cnt_q[c] < WR_LAST) ? (cnt_q[c] + CNT_W'(1)) : '0;
            end else begin
                cnt_d[c] = '0;
            end

            rdy_s[c]    = (rd_act_s[c] & (cnt_q[c] == RD_LAST)) |
                          (wr_act_s[c] & (cnt_q[c] == WR_LAST));
            commit_s[c] = wr_act_s[c] & rdy_s[c];

            if (in_range_s[c]) begin
                rdata_d[c]  = mem_q[idx_s[c]];
                wmerge_s[c] = (bus.ch_wdata[c*DATA_W +: DATA_W] & size_mask(bus.ch_size[c*SIZE_W +: SIZE_W])) |
                              (mem_q[idx_s[c]] & ~size_mask(bus.ch_size[c*SIZE_W +: SIZE_W]));
            end else begin
                rdata_d[c]  = '0;
                wmerge_s[c] = '0;
            end

            rdata_flat_s[c*DATA_W +: DATA_W] = rdata_q[c];
        end
    end

    // Channel state registers: counters, read data and sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c]   <= '0;
                rdata_q[c] <= '0;
            end
            err_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c]   <= cnt_d[c];
                rdata_q[c] <= rdata_d[c];
            end
            err_q <= err_d;
        end
    end

    // Array update: later assignments win, giving load > highest channel > lower channels.
    // Reset aborts pending channel writes; the array itself is never cleared.
    always_ff @(posedge clock) begin
        for (int c = 0; c < N_CH; c++) begin
            if (!reset && commit_s[c]) begin
                mem_q[idx_s[c]] <= wmerge_s[c];
            end
        end
        if (bus.load_en) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.ch_rdy   = rdy_s;
    assign bus.ch_rdata = rdata_flat_s;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_offchip_mem_model_nch.sv
// ----------------------------------------------------------------------------
// tb_offchip_mem_model_nch
// Directed bench for offchip_mem_model_nch. Instance A uses the default
// latencies (RD 2, WR 1) and is driven from a per-cycle vector table; instance
// B uses RD 4, WR 3 and is exercised with hand-written multi-cycle sequences.
// Inputs change 1 time unit after the rising edge, outputs are sampled 2 units
// later, well clear of the next edge.
// ----------------------------------------------------------------------------
module tb_offchip_mem_model_nch;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;

    offchip_mem_model_nch_if #(.N_CH(2), .ADDR_W(7), .DATA_W(8), .SIZE_W(4), .MEMSIZE(64)) bus_a ();
    offchip_mem_model_nch_if #(.N_CH(2), .ADDR_W(7), .DATA_W(8), .SIZE_W(4), .MEMSIZE(64)) bus_b ();

    offchip_mem_model_nch #(.RD_DELAY(2), .WR_DELAY(1)) u_a (
        .clock (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    offchip_mem_model_nch #(.RD_DELAY(4), .WR_DELAY(3)) u_b (
        .clock (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] oe;
        logic [1:0] we;
        logic [6:0] a0;
        logic [6:0] a1;
        logic [7:0] wd0;
        logic [7:0] wd1;
        logic [3:0] sz0;
        logic [3:0] sz1;
        logic       ld;
        logic [5:0] ld_a;
        logic [7:0] ld_d;
        logic [1:0] e_rdy;
        logic       chk_rd;
        logic [7:0] e_rd0;
        logic [7:0] e_rd1;
        logic [1:0] e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] oe, input logic [1:0] we,
                                input logic [6:0] a0, input logic [6:0] a1,
                                input logic [7:0] wd0, input logic [7:0] wd1,
                                input logic [3:0] sz0, input logic [3:0] sz1,
                                input logic ld, input logic [5:0] ld_a, input logic [7:0] ld_d,
                                input logic [1:0] e_rdy, input logic chk_rd,
                                input logic [7:0] e_rd0, input logic [7:0] e_rd1,
                                input logic [1:0] e_err);
        vec_t v;
        v.rst = rst;   v.oe = oe;     v.we = we;     v.a0 = a0;       v.a1 = a1;
        v.wd0 = wd0;   v.wd1 = wd1;   v.sz0 = sz0;   v.sz1 = sz1;
        v.ld = ld;     v.ld_a = ld_a; v.ld_d = ld_d;
        v.e_rdy = e_rdy; v.chk_rd = chk_rd; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic [1:0] oe, input logic [1:0] we, input logic [6:0] a0, input logic [6:0] a1,
                         input logic [7:0] wd0, input logic [7:0] wd1, input logic [3:0] s0, input logic [3:0] s1);
        bus_a.ch_oe    = oe;
        bus_a.ch_we    = we;
        bus_a.ch_addr  = {a1, a0};
        bus_a.ch_wdata = {wd1, wd0};
        bus_a.ch_size  = {s1, s0};
    endtask

    task automatic drv_b(input logic [1:0] oe, input logic [1:0] we, input logic [6:0] a0, input logic [6:0] a1,
                         input logic [7:0] wd0, input logic [7:0] wd1, input logic [3:0] s0, input logic [3:0] s1);
        bus_b.ch_oe    = oe;
        bus_b.ch_we    = we;
        bus_b.ch_addr  = {a1, a0};
        bus_b.ch_wdata = {wd1, wd0};
        bus_b.ch_size  = {s1, s0};
    endtask

    initial begin
        logic [7:0] pre;
        checks = 0;
        errors = 0;

        // Idle: addresses out of range so read registers stay at zero.
        rst_a = 1'b1;
        rst_b = 1'b1;
        drv_a(2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0);
        drv_b(2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0);
        bus_a.load_en = 1'b0; bus_a.load_addr = 6'd0; bus_a.load_data = 8'h00;
        bus_b.load_en = 1'b0; bus_b.load_addr = 6'd0; bus_b.load_data = 8'h00;
        #1;
        step();
        step();

        // Reset state.
        #2;
        chk("rst A rdy", 8'(bus_a.ch_rdy), 8'h00);
        chk("rst A rdata", bus_a.ch_rdata[7:0] | bus_a.ch_rdata[15:8], 8'h00);
        chk("rst A err", 8'(bus_a.err), 8'h00);
        chk("rst B rdy", 8'(bus_b.ch_rdy), 8'h00);
        chk("rst B err", 8'(bus_b.err), 8'h00);
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Preload both arrays: mem[i] = i, except idx3 = A5 and idx5 = 00.
        for (int i = 0; i < 64; i++) begin
            pre = (i == 3) ? 8'hA5 : ((i == 5) ? 8'h00 : 8'(i));
            bus_a.load_en = 1'b1; bus_a.load_addr = 6'(i); bus_a.load_data = pre;
            bus_b.load_en = 1'b1; bus_b.load_addr = 6'(i); bus_b.load_data = pre;
            step();
        end
        bus_a.load_en = 1'b0;
        bus_b.load_en = 1'b0;

        //                 rst   oe     we     a0      a1      wd0    wd1    sz0   sz1   ld    ld_a   ld_d   e_rdy  chk   e_rd0  e_rd1  e_err
        // held read of idx3: rdy every 2nd cycle
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 7'd3,   7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 7'd3,   7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b01, 1'b1, 8'hA5, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 7'd3,   7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'hA5, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 7'd3,   7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b01, 1'b1, 8'hA5, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'hA5, 8'h00, 2'b00));
        // ch1 size-4 write of FF over 00 at idx5, then read back (first sample is pre-write)
        vecs.push_back(mk(1'b0, 2'b00, 2'b10, 7'd100, 7'd5,   8'h00, 8'hFF, 4'd0, 4'd4, 1'b0, 6'd0,  8'h00, 2'b10, 1'b1, 8'h00, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b10, 2'b00, 7'd100, 7'd5,   8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b10, 2'b00, 7'd100, 7'd5,   8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b10, 1'b1, 8'h00, 8'h0F, 2'b00));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h00, 8'h0F, 2'b00));
        // both channels write idx7: ch1 wins
        vecs.push_back(mk(1'b0, 2'b00, 2'b11, 7'd7,   7'd7,   8'h11, 8'h22, 4'd8, 4'd8, 1'b0, 6'd0,  8'h00, 2'b11, 1'b1, 8'h00, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 7'd7,   7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h07, 8'h07, 2'b00));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 7'd7,   7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b01, 1'b1, 8'h22, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h22, 8'h00, 2'b00));
        // size-0 write leaves idx10; preload beats ch1 at idx9
        vecs.push_back(mk(1'b0, 2'b00, 2'b11, 7'd10,  7'd9,   8'hFF, 8'h33, 4'd0, 4'd8, 1'b1, 6'd9,  8'h5A, 2'b11, 1'b1, 8'h00, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 7'd10,  7'd9,   8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h0A, 8'h09, 2'b00));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 7'd10,  7'd9,   8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b11, 1'b1, 8'h0A, 8'h5A, 2'b00));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h0A, 8'h5A, 2'b00));
        // ch1 oe+we: sticky error, no write to idx2
        vecs.push_back(mk(1'b0, 2'b10, 2'b10, 7'd100, 7'd2,   8'h00, 8'hFF, 4'd0, 4'd8, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b10));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b10));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 7'd2,   7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b10));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 7'd2,   7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b01, 1'b1, 8'h02, 8'h00, 2'b10));
        // reset clears err and rdata but keeps the array
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h02, 8'h00, 2'b10));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 7'd7,   7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 7'd7,   7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b01, 1'b1, 8'h22, 8'h00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 6'd0,  8'h00, 2'b00, 1'b1, 8'h22, 8'h00, 2'b00));

        foreach (vecs[i]) begin
            rst_a = vecs[i].rst;
            drv_a(vecs[i].oe, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].wd0, vecs[i].wd1, vecs[i].sz0, vecs[i].sz1);
            bus_a.load_en   = vecs[i].ld;
            bus_a.load_addr = vecs[i].ld_a;
            bus_a.load_data = vecs[i].ld_d;
            #2;
            chk($sformatf("v%0d rdy", i), 8'(bus_a.ch_rdy), 8'(vecs[i].e_rdy));
            chk($sformatf("v%0d err", i), 8'(bus_a.err), 8'(vecs[i].e_err));
            if (vecs[i].chk_rd) begin
                chk($sformatf("v%0d rdata0", i), bus_a.ch_rdata[7:0], vecs[i].e_rd0);
                chk($sformatf("v%0d rdata1", i), bus_a.ch_rdata[15:8], vecs[i].e_rd1);
            end
            step();
        end
        rst_a = 1'b0;
        bus_a.load_en = 1'b0;

        // Out-of-range read (addr 64) held for 10 cycles.
        drv_a(2'b01, 2'b00, 7'd64, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0);
        for (int k = 0; k < 10; k++) begin
            #2;
            chk($sformatf("oor%0d rdy", k), 8'(bus_a.ch_rdy), 8'h00);
            chk($sformatf("oor%0d rdata0", k), bus_a.ch_rdata[7:0], 8'h00);
            chk($sformatf("oor%0d err", k), 8'(bus_a.err), 8'h00);
            step();
        end
        drv_a(2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0);

        // Instance B: read of idx3 held for 8 cycles, rdy on every 4th.
        drv_b(2'b01, 2'b00, 7'd3, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0);
        for (int k = 0; k < 8; k++) begin
            #2;
            chk($sformatf("B rd%0d rdy", k), 8'(bus_b.ch_rdy), (k % 4 == 3) ? 8'h01 : 8'h00);
            chk($sformatf("B rd%0d rdata0", k), bus_b.ch_rdata[7:0], (k == 0) ? 8'h00 : 8'hA5);
            step();
        end

        // Instance B: 3-cycle write of 77 to idx12, rdy on the 3rd cycle.
        drv_b(2'b00, 2'b10, 7'd100, 7'd12, 8'h00, 8'h77, 4'd0, 4'd8);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("B wr%0d rdy", k), 8'(bus_b.ch_rdy), (k == 2) ? 8'h02 : 8'h00);
            step();
        end
        drv_b(2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0);
        step();
        drv_b(2'b01, 2'b00, 7'd12, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            #2;
            if (k == 3) begin
                chk("B wr readback rdy", 8'(bus_b.ch_rdy), 8'h01);
                chk("B wr readback data", bus_b.ch_rdata[7:0], 8'h77);
            end
            step();
        end

        // Instance B: reset in the rdy cycle of a write aborts the commit.
        drv_b(2'b00, 2'b10, 7'd100, 7'd13, 8'h00, 8'h99, 4'd0, 4'd8);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                rst_b = 1'b1;
            end
            #2;
            if (k == 2) begin
                chk("B abort rdy", 8'(bus_b.ch_rdy), 8'h02);
            end
            step();
        end
        rst_b = 1'b0;
        drv_b(2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0);
        step();
        drv_b(2'b01, 2'b00, 7'd13, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            #2;
            if (k == 3) begin
                chk("B abort readback rdy", 8'(bus_b.ch_rdy), 8'h01);
                chk("B abort readback data", bus_b.ch_rdata[7:0], 8'h0D);
            end
            step();
        end
        drv_b(2'b00, 2'b00, 7'd100, 7'd100, 8'h00, 8'h00, 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
